pc_fetch_gen: RTL

Parametrised program-counter generator for the IF stage. Replaces the single-word PC with an aligned multi-word fetch address generator that talks to instruction memory over a req/ready handshake. It arbitrates exception and branch redirects, and holds a redirect that cannot be consumed yet in a pending register. It sits between the pipeline control (stall, branch, exception) and the instruction-fetch memory port.

---
 rtl/pc_fetch_gen.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_gen.sv
// -----------------------------------------------------------------------------
// pc_fetch_gen
// Program-counter generator for the instruction-fetch stage. It issues
// FETCH_BYTES-aligned fetch requests over a req/ready handshake. It also
// arbitrates exception and branch redirects. A redirect that arrives while a
// request is still outstanding is parked in a one-entry pending register. That
// entry is applied on the accept edge.
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined   : a redirect target with target[1:0] != 0 enters FAULT
//               (adel_flag=1). Only an exception redirect leaves FAULT.
//   undefined : target[1:0] is forced to zero, and adel_flag is tied low.
//
// Ports
//   clk              in   clock, all logic on posedge
//   rst              in   synchronous active-high reset
//   stall_pc         in   freeze issue of new fetch requests
//   exc_flag         in   exception redirect (highest priority)
//   exc_addr         in   exception target
//   branch_flag      in   branch redirect
//   branch_addr      in   branch target
//   fetch_req        out  fetch request valid (registered)
//   fetch_addr       out  aligned fetch address (registered)
//   fetch_first_slot out  first valid 32-bit word within the beat
//   fetch_ready      in   memory accepts the request this cycle
//   redirect_pending out  a stored redirect is waiting
//   adel_flag        out  misaligned redirect fault
// -----------------------------------------------------------------------------
module pc_fetch_gen #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'hbfc00000,
    parameter int                    FETCH_BYTES  = 4,
    localparam int                   OFF_W        = $clog2(FETCH_BYTES),
    localparam int                   SLOT_W       = (OFF_W > 3) ? (OFF_W - 2) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_pc,
    input  logic                  exc_flag,
    input  logic [ADDR_WIDTH-1:0] exc_addr,
    input  logic                  branch_flag,
    input  logic [ADDR_WIDTH-1:0] branch_addr,
    output logic                  fetch_req,
    output logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [SLOT_W-1:0]     fetch_first_slot,
    input  logic                  fetch_ready,
    output logic                  redirect_pending,
    output logic                  adel_flag
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    // Clear the byte-offset bits so the address points at the start of a beat.
    function automatic logic [ADDR_WIDTH-1:0] align_down(input logic [ADDR_WIDTH-1:0] a);
        return a & ~ADDR_WIDTH'(FETCH_BYTES - 1);
    endfunction

    // Word index inside the beat. It is always zero when a beat is a single word.
    function automatic logic [SLOT_W-1:0] slot_of(input logic [ADDR_WIDTH-1:0] a);
        return SLOT_W'((a >> 2) & ADDR_WIDTH'(FETCH_BYTES / 4 - 1));
    endfunction

    // Without the alignment check, the two byte-offset bits of a target are dropped.
    function automatic logic [ADDR_WIDTH-1:0] sanitize(input logic [ADDR_WIDTH-1:0] a);
`ifdef PC_ALIGN_CHECK_EN
        return a;
`else
        return {a[ADDR_WIDTH-1:2], 2'b00};
`endif
    endfunction

    state_t                  state_q, state_d;
    logic                    boot_q, boot_d;
    logic                    fetch_req_q, fetch_req_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic                    pend_v_q, pend_v_d;
    logic [ADDR_WIDTH-1:0]   pend_tgt_q, pend_tgt_d;
    logic                    hold_exc_q, hold_exc_d;
    logic                    redir_s;
    logic [ADDR_WIDTH-1:0]   redir_tgt_s;
    logic [ADDR_WIDTH-1:0]   clean_tgt_s;

    // Next-state logic. It covers the handshake, the pending capture and the redirect selection.
    always_comb begin
        state_d     = state_q;
        boot_d      = boot_q;
        addr_d      = addr_q;
        slot_d      = slot_q;
        pend_v_d    = pend_v_q;
        pend_tgt_d  = pend_tgt_q;
        hold_exc_d  = 1'b0;
        redir_s     = 1'b0;
        redir_tgt_s = '0;
        clean_tgt_s = '0;
        case (state_q)
            S_IDLE: begin
                // boot_q keeps IDLE for one extra edge after reset.
                // As a result, the first request rises two edges after the last reset edge.
                if (boot_q) begin
                    boot_d = 1'b0;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (fetch_ready) begin
                    pend_v_d = 1'b0;
                    state_d  = stall_pc ? S_HOLD : S_REQ;
                    if (exc_flag) begin
                        redir_s     = 1'b1;
                        redir_tgt_s = exc_addr;
                    end else if (pend_v_q) begin
                        redir_s     = 1'b1;
                        redir_tgt_s = pend_tgt_q;
                    end else if (branch_flag) begin
                        redir_s     = 1'b1;
                        redir_tgt_s = branch_addr;
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(FETCH_BYTES);
                        slot_d = '0;
                    end
                end else begin
                    // An exception replaces any stored target.
                    // A branch only fills an empty entry.
                    if (exc_flag) begin
                        pend_v_d   = 1'b1;
                        pend_tgt_d = exc_addr;
                    end else if (branch_flag && !pend_v_q) begin
                        pend_v_d   = 1'b1;
                        pend_tgt_d = branch_addr;
                    end else begin
                        pend_v_d = pend_v_q;
                    end
                end
            end
            S_HOLD: begin
                state_d = stall_pc ? S_HOLD : S_REQ;
                // hold_exc_q records that an exception already loaded fetch_addr in this HOLD stretch.
                // A later branch in the same stretch must not replace that target.
                if (exc_flag) begin
                    redir_s     = 1'b1;
                    redir_tgt_s = exc_addr;
                    hold_exc_d  = stall_pc;
                end else if (branch_flag && !hold_exc_q) begin
                    redir_s     = 1'b1;
                    redir_tgt_s = branch_addr;
                    hold_exc_d  = 1'b0;
                end else begin
                    hold_exc_d = stall_pc & hold_exc_q;
                end
            end
            S_FAULT: begin
                if (exc_flag) begin
                    redir_s     = 1'b1;
                    redir_tgt_s = exc_addr;
                    state_d     = S_REQ;
                end else begin
                    state_d = S_FAULT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (redir_s) begin
            clean_tgt_s = sanitize(redir_tgt_s);
            slot_d      = slot_of(clean_tgt_s);
            addr_d      = align_down(clean_tgt_s);
`ifdef PC_ALIGN_CHECK_EN
            // A misaligned target parks in FAULT.
            // fetch_addr then holds the raw target for the trap handler.
            if (clean_tgt_s[1:0] != 2'b00) begin
                state_d    = S_FAULT;
                addr_d     = clean_tgt_s;
                hold_exc_d = 1'b0;
            end else begin
                addr_d = align_down(clean_tgt_s);
            end
`endif
        end else begin
            clean_tgt_s = '0;
        end
    end

    assign fetch_req_d = (state_d == S_REQ);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            boot_q      <= 1'b1;
            fetch_req_q <= 1'b0;
            addr_q      <= align_down(RESET_VECTOR);
            slot_q      <= slot_of(RESET_VECTOR);
            pend_v_q    <= 1'b0;
            pend_tgt_q  <= '0;
            hold_exc_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            boot_q      <= boot_d;
            fetch_req_q <= fetch_req_d;
            addr_q      <= addr_d;
            slot_q      <= slot_d;
            pend_v_q    <= pend_v_d;
            pend_tgt_q  <= pend_tgt_d;
            hold_exc_q  <= hold_exc_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic adel_q;

    // Fault flag register. It is set for as long as the block sits in FAULT.
    always_ff @(posedge clk) begin
        if (rst) begin
            adel_q <= 1'b0;
        end else begin
            adel_q <= (state_d == S_FAULT);
        end
    end

    assign adel_flag = adel_q;
`else
    assign adel_flag = 1'b0;
`endif

    assign fetch_req        = fetch_req_q;
    assign fetch_addr       = addr_q;
    assign fetch_first_slot = slot_q;
    assign redirect_pending = pend_v_q;

endmodule
